uart_32_bit_receiver: RTL and testbench
=======================================

// Module: uart_32_bit_receiver
// PURPOSE
//   UART serial receiver that consumes the 16x-oversample baud_tick from the baud rate
//   generator. Recovers 8N1 frames on rx and packs four bytes, little-endian, into one
//   32-bit word. Presents the word on a valid/ready interface.
//   Flags framing and overrun errors. Sits between the pad-side rx line and the host bus.
// PARAMETERS
//   OVERSAMPLE      16  baud_ticks per bit; must be even and >= 4
//   DATA_BITS       8   data bits per frame, LSB first
//   BYTES_PER_WORD  4   frames packed per output word (word width = 32)
// PORTS
//   clk            in   1   system clock; all logic on posedge
//   rst            in   1   synchronous, active-high reset
//   baud_tick      in   1   1-cycle oversample strobe (OVERSAMPLE x baud rate)
//   rx             in   1   asynchronous serial input, idle high
//   rx_ready       in   1   consumer accepts rx_data when rx_valid && rx_ready
//   rx_data        out  32  received word; byte0 = first byte received, in [7:0]
//   rx_valid       out  1   rx_data holds an unconsumed word
//   frame_error    out  1   1-cycle pulse: stop bit sampled low
//   overrun_error  out  1   1-cycle pulse: a completed word was dropped
//   busy           out  1   high whenever the FSM is not IDLE
// BEHAVIOUR
//   Reset
//   - Reset values: rx_data=0, rx_valid=0, frame_error=0, overrun_error=0, busy=0.
//   - The 2-FF rx synchronizer resets to 1.
//   - Reset also clears the FSM, tick_cnt, bit_cnt, byte_idx and the partial word.
//   - Reset mid-frame discards all partial data.
//   Sampling
//   - rx passes through a 2-FF synchronizer (rx_s).
//   - FSM state, tick_cnt, bit_cnt and the sampling points advance only on cycles where
//     baud_tick=1. With no ticks the receiver is frozen; no timeout.
//   FSM states and transitions
//   - IDLE: on a tick with rx_s==0, go to START with tick_cnt=0.
//   - START: on the tick where tick_cnt==OVERSAMPLE/2-1, sample rx_s.
//     - rx_s==0: go to DATA with tick_cnt=0 and bit_cnt=0.
//     - rx_s==1: treat as a glitch and return to IDLE; no flag.
//   - DATA: on the tick where tick_cnt==OVERSAMPLE-1, shift rx_s in LSB-first and
//     increment bit_cnt. After DATA_BITS samples, go to STOP.
//   - STOP: on the tick where tick_cnt==OVERSAMPLE-1, sample rx_s, then always go to IDLE.
//     - rx_s==1: write the byte to word[8*byte_idx +: 8] and increment byte_idx.
//     - rx_s==0: pulse frame_error, discard the byte, clear byte_idx to 0 and drop the
//       partial word.
//   - tick_cnt counts 0..OVERSAMPLE-1 and wraps.
//   Word completion
//   - The 4th good byte triggers completion and byte_idx wraps to 0.
//   - Output register free (!rx_valid, or rx_valid && rx_ready this cycle):
//     rx_data<=word and rx_valid<=1 on the next edge.
//   - Output register occupied and not being accepted: pulse overrun_error, drop the
//     new word, keep rx_data unchanged.
//   - A handshake on the same cycle as completion loads the new word, rx_valid stays 1,
//     and there is no overrun.
//   Output handshake
//   - rx_valid falls on the edge after rx_valid && rx_ready when no word completes.
//   - rx_data is stable while rx_valid=1.
//   Latency
//   - rx_valid rises 1 clk after the stop-bit sampling tick of byte 3, plus 2 clks of
//     synchronizer delay relative to rx.
// TESTING
//   Bench setup: baud_tick every 4 clks, so 1 bit = 64 clks.
//   1 Send 0x78,0x56,0x34,0x12 (good stops), rx_ready=1 -> one rx_valid with
//     rx_data=0x12345678; no error pulses.
//   2 rx low for 4 ticks, then high -> START aborts, busy returns to 0, no rx_valid,
//     no frame_error.
//   3 Send 0x11, then 0x22 with stop bit=0 -> frame_error pulses once. Then send
//     AA,BB,CC,DD -> rx_data=0xDDCCBBAA.
//   4 rx_ready=0, send 8 bytes 01..08 -> rx_data=0x04030201 stays held and
//     overrun_error pulses once. rx_ready=1 -> rx_valid drops.
//   5 Assert rst mid-bit of byte 3 -> all outputs 0 the next cycle. Then send
//     DE,AD,BE,EF -> rx_data=0xEFBEADDE.
//   6 Hold baud_tick=0 for 100 clks mid-DATA while rx is held -> state frozen. On resume,
//     the byte decodes correctly.

Source files
------------

// File: rtl/uart_32_bit_receiver_if.sv
// Valid/ready word interface between the UART receiver and its consumer.
// The receiver drives data/valid and the consumer drives ready.
interface uart_32_bit_receiver_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_32_bit_receiver.sv
// 8N1 UART receiver on a 16x oversample tick; packs four bytes little-endian
// into one word presented on a valid/ready interface, with framing/overrun pulses.
module uart_32_bit_receiver #(
  parameter int unsigned OVERSAMPLE     = 16,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned BYTES_PER_WORD = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          baud_tick,
  input  logic                          rx,
  output logic                          frame_error,
  output logic                          overrun_error,
  output logic                          busy,
  uart_32_bit_receiver_if.master        bus
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int unsigned IW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int unsigned WW = DATA_BITS * BYTES_PER_WORD;

  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [IW-1:0] BYTE_LAST = IW'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q, state_d;
  logic                 rx_meta, rx_s;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IW-1:0]        byte_q, byte_d;
  logic [WW-1:0]        word_q, word_d, word_tmp;
  logic [WW-1:0]        data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 ov_q, ov_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      word_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    word_d   = word_q;
    data_d   = data_q;
    valid_d  = valid_q;
    fe_d     = 1'b0;
    ov_d     = 1'b0;
    word_tmp = word_q;

    if (valid_q && bus.rx_ready) valid_d = 1'b0;

    if (baud_tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            tick_d  = '0;
          end
        end
        START: begin
          if (tick_q == TICK_HALF) begin
            tick_d = '0;
            if (!rx_s) begin
              state_d = DATA;
              bit_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_q == BIT_LAST) begin
              state_d = STOP;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        STOP: begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            state_d = IDLE;
            if (rx_s) begin
              word_tmp[DATA_BITS*byte_q +: DATA_BITS] = shift_q;
              if (byte_q == BYTE_LAST) begin
                byte_d = '0;
                word_d = '0;
                // A same-cycle handshake frees the output register for the new word.
                if (!valid_q || bus.rx_ready) begin
                  data_d  = word_tmp;
                  valid_d = 1'b1;
                end else begin
                  ov_d = 1'b1;
                end
              end else begin
                byte_d = byte_q + 1'b1;
                word_d = word_tmp;
              end
            end else begin
              fe_d   = 1'b1;
              byte_d = '0;
              word_d = '0;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign frame_error   = fe_q;
  assign overrun_error = ov_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_32_bit_receiver.sv
// Self-checking bench for uart_32_bit_receiver: table-driven frame vectors,
// hand-written corner sequences and a randomized run against a byte-level model.
module tb_uart_32_bit_receiver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic tick_en = 1'b1;
  logic baud_tick;
  logic frame_error, overrun_error, busy;
  int unsigned tick_div = 0;

  uart_32_bit_receiver_if #(.WIDTH(32)) bus ();

  uart_32_bit_receiver #(
    .OVERSAMPLE(16),
    .DATA_BITS(8),
    .BYTES_PER_WORD(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .baud_tick(baud_tick),
    .rx(rx),
    .frame_error(frame_error),
    .overrun_error(overrun_error),
    .busy(busy),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tick_div <= (tick_div == 3) ? 0 : tick_div + 1;
  assign baud_tick = tick_en && (tick_div == 3);

  // Monitor: sampled on the falling edge, away from the active edge.
  logic [31:0] got_q[$];
  int fe_cnt = 0;
  int ov_cnt = 0;
  always @(negedge clk) begin
    if (bus.rx_valid && bus.rx_ready) got_q.push_back(bus.rx_data);
    if (frame_error) fe_cnt++;
    if (overrun_error) ov_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v, input bit pause);
    rx = v;
    if (pause) begin
      wait_clks(32);
      tick_en = 1'b0;
      wait_clks(50);
      check("pause_busy", {31'b0, busy}, 32'd1);
      wait_clks(50);
      tick_en = 1'b1;
      wait_clks(32);
    end else begin
      wait_clks(64);
    end
  endtask

  // Start, 8 data bits LSB first, stop, then one idle bit time.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input bit pause);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], pause && (i == 3));
    send_bit(stop_ok, 1'b0);
    send_bit(1'b1, 1'b0);
  endtask

  typedef struct {
    int          n;
    logic [63:0] bytes;
    logic [7:0]  stops;
    int          pause_frame;
    int          exp_words;
    logic [31:0] exp_last;
    int          exp_fe;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int g0, f0, o0;
    logic [7:0] part[$];
    logic [31:0] exp_q[$];
    int fe_exp;

    vecs[0] = '{4, 64'h0000_0000_1234_5678, 8'h0F, -1, 1, 32'h1234_5678, 0};
    vecs[1] = '{6, 64'h0000_DDCC_BBAA_2211, 8'h3D, -1, 1, 32'hDDCC_BBAA, 1};
    vecs[2] = '{4, 64'h0000_0000_A555_FF00, 8'h0F, -1, 1, 32'hA555_FF00, 0};
    vecs[3] = '{4, 64'h0000_0000_0403_0201, 8'h07, -1, 0, 32'h0, 1};
    vecs[4] = '{4, 64'h0000_0000_7E81_C33C, 8'h0F, 1, 1, 32'h7E81_C33C, 0};
    vecs[5] = '{8, 64'h0807_0605_0403_0201, 8'hFF, -1, 2, 32'h0807_0605, 0};

    bus.rx_ready = 1'b1;
    rst = 1'b1;
    wait_clks(3);
    check("reset_rx_data", bus.rx_data, 32'h0);
    check("reset_rx_valid", {31'b0, bus.rx_valid}, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_errors", {30'b0, frame_error, overrun_error}, 32'h0);
    rst = 1'b0;
    wait_clks(4);

    // Table-driven frame sequences with rx_ready held high.
    for (int v = 0; v < 6; v++) begin
      g0 = got_q.size(); f0 = fe_cnt; o0 = ov_cnt;
      for (int f = 0; f < vecs[v].n; f++)
        send_frame(vecs[v].bytes[8*f +: 8], vecs[v].stops[f], f == vecs[v].pause_frame);
      wait_clks(4);
      check($sformatf("vec%0d_words", v), got_q.size() - g0, vecs[v].exp_words);
      if (vecs[v].exp_words > 0)
        check($sformatf("vec%0d_last", v), got_q[$], vecs[v].exp_last);
      check($sformatf("vec%0d_frame_err", v), fe_cnt - f0, vecs[v].exp_fe);
      check($sformatf("vec%0d_overrun", v), ov_cnt - o0, 0);
      check($sformatf("vec%0d_idle", v), {30'b0, busy, bus.rx_valid}, 32'h0);
    end

    // Short start glitch: START aborts silently.
    g0 = got_q.size(); f0 = fe_cnt;
    rx = 1'b0;
    wait_clks(16);
    check("glitch_busy_high", {31'b0, busy}, 32'd1);
    rx = 1'b1;
    wait_clks(64);
    check("glitch_busy_low", {31'b0, busy}, 32'd0);
    check("glitch_no_word", got_q.size() - g0, 0);
    check("glitch_no_fe", fe_cnt - f0, 0);
    check("glitch_no_valid", {31'b0, bus.rx_valid}, 32'd0);

    // Consumer stalled: second word overruns, first is held.
    bus.rx_ready = 1'b0;
    g0 = got_q.size(); o0 = ov_cnt; f0 = fe_cnt;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0);
    check("stall_valid", {31'b0, bus.rx_valid}, 32'd1);
    check("stall_data", bus.rx_data, 32'h0403_0201);
    for (int i = 5; i <= 8; i++) send_frame(8'(i), 1'b1, 1'b0);
    check("overrun_count", ov_cnt - o0, 1);
    check("overrun_data_held", bus.rx_data, 32'h0403_0201);
    check("overrun_valid_held", {31'b0, bus.rx_valid}, 32'd1);
    bus.rx_ready = 1'b1;
    wait_clks(1);
    check("drain_valid_low", {31'b0, bus.rx_valid}, 32'd0);
    check("drain_words", got_q.size() - g0, 1);
    check("drain_word", got_q[$], 32'h0403_0201);
    check("stall_no_fe", fe_cnt - f0, 0);

    // Reset mid-bit of the fourth byte discards the partial word.
    for (int i = 0; i < 3; i++) send_frame(8'h11 * 8'(i + 1), 1'b1, 1'b0);
    check("pre_reset_data", bus.rx_data, 32'h0403_0201);
    rx = 1'b0;
    wait_clks(64);
    rx = 1'b1;
    wait_clks(30);
    rst = 1'b1;
    wait_clks(1);
    check("midrst_rx_data", bus.rx_data, 32'h0);
    check("midrst_valid", {31'b0, bus.rx_valid}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_errors", {30'b0, frame_error, overrun_error}, 32'h0);
    rst = 1'b0;
    wait_clks(128);
    g0 = got_q.size();
    send_frame(8'hDE, 1'b1, 1'b0);
    send_frame(8'hAD, 1'b1, 1'b0);
    send_frame(8'hBE, 1'b1, 1'b0);
    send_frame(8'hEF, 1'b1, 1'b0);
    wait_clks(4);
    check("post_reset_words", got_q.size() - g0, 1);
    check("post_reset_word", got_q[$], 32'hEFBE_ADDE);

    // Randomized frames against a byte-level model.
    g0 = got_q.size(); f0 = fe_cnt; o0 = ov_cnt;
    fe_exp = 0;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      logic s;
      b = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
      send_frame(b, s, 1'b0);
      if (s) begin
        part.push_back(b);
        if (part.size() == 4) begin
          exp_q.push_back({part[3], part[2], part[1], part[0]});
          part.delete();
        end
      end else begin
        part.delete();
        fe_exp++;
      end
    end
    wait_clks(4);
    check("rand_words", got_q.size() - g0, exp_q.size());
    for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++)
      check($sformatf("rand_word%0d", i), got_q[g0 + i], exp_q[i]);
    check("rand_frame_err", fe_cnt - f0, fe_exp);
    check("rand_overrun", ov_cnt - o0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
